// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // A one-step operation still needs a one-bit counter.
    function automatic int calc_cnt_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = calc_cnt_w(calc_steps(8, 1));

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder cell, chained by the serial adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_pipe.sv
// Multi-cycle adder resolving BITS_PER_CYCLE bits per clock behind valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b) and the signed ovf output.
module serial_adder_pipe
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = calc_cnt_w(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t                  state, state_nxt;
    logic [WIDTH-1:0]        a_sh, b_sh, sum_sh, sum_sh_nxt;
    logic                    carry;
    logic [CNT_W-1:0]        cnt;
    logic [BITS_PER_CYCLE:0] chain;
    logic [BITS_PER_CYCLE-1:0] slice;
    logic                    accept, last_step;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (state == RUN) && (cnt == LAST_STEP);

    assign chain[0] = carry;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        full_adder_bit u_fa (
            .a    (a_sh[i]),
            .b    (b_sh[i]),
            .cin  (chain[i]),
            .sum  (slice[i]),
            .cout (chain[i+1])
        );
    end

    // New slice enters at the top so the first (LSB) slice ends at bit 0.
    if (STEPS == 1) begin : g_single
        assign sum_sh_nxt = slice;
    end else begin : g_multi
        assign sum_sh_nxt = {slice, sum_sh[WIDTH-1:BITS_PER_CYCLE]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= a;
`ifdef SERIAL_ADDER_SUB_EN
            // Two's-complement subtract: invert b and force the carry-in.
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            b_sh  <= b;
            carry <= cin;
`endif
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> BITS_PER_CYCLE;
            b_sh   <= b_sh >> BITS_PER_CYCLE;
            sum_sh <= sum_sh_nxt;
            carry  <= chain[BITS_PER_CYCLE];
            cnt    <= cnt + 1'b1;
            if (last_step) begin
                sum  <= sum_sh_nxt;
                cout <= chain[BITS_PER_CYCLE];
`ifdef SERIAL_ADDER_SUB_EN
                ovf  <= chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_pipe.sv
// Directed bench for serial_adder_pipe at 8x1 and 8x4 bits per cycle.
// Subtract-mode vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv1, ir1, ov1, or1, cin1, cout1, busy1;
    logic [7:0] a1, b1, sum1;
    logic       iv4, ir4, ov4, or4, cin4, cout4, busy4;
    logic [7:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub1, ovf1, sub4, ovf4;
`endif

    int         errors = 0;
    int         checks = 0;
    int         lat;
    logic [8:0] ref9;

    serial_adder_pipe #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub1), .ovf(ovf1),
`endif
        .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(cout1), .busy(busy1)
    );

    serial_adder_pipe #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4), .ovf(ovf4),
`endif
        .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
    endtask

    task automatic start4(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
    endtask

    task automatic wait1(input string tag, input int exp_lat);
        lat = 0;
        while (!ov1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check(tag, lat, exp_lat);
    endtask

    task automatic wait4(input string tag, input int exp_lat);
        lat = 0;
        while (!ov4 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check(tag, lat, exp_lat);
    endtask

    task automatic release1();
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        check("x1_release_ov", ov1, 1'b0);
        check("x1_release_ir", ir1, 1'b1);
    endtask

    task automatic release4();
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        check("x4_release_ov", ov4, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; cin4 = 0;
`ifdef SERIAL_ADDER_SUB_EN
        sub1 = 0; sub4 = 0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ir1", ir1, 1'b1);
        check("rst_ov1", ov1, 1'b0);
        check("rst_sum1", sum1, 8'h00);
        check("rst_cout1", cout1, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_ir4", ir4, 1'b1);
        check("rst_ov4", ov4, 1'b0);
        rst_n = 1'b1;

        // 0x0F + 0x01, then hold the result under backpressure
        start1(8'h0F, 8'h01, 1'b0);
        check("x1_busy_run", busy1, 1'b1);
        check("x1_ir_run", ir1, 1'b0);
        wait1("x1_lat_0f", 8);
        check("x1_sum_0f", sum1, 8'h10);
        check("x1_cout_0f", cout1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                a1 = 8'hAA; b1 = 8'h55; iv1 = 1'b1;
            end else begin
                iv1 = 1'b0;
            end
            @(negedge clk);
            check("bp_ov", ov1, 1'b1);
            check("bp_sum", sum1, 8'h10);
            check("bp_ir", ir1, 1'b0);
        end
        iv1 = 1'b0;
        release1();
        check("bp_idle_busy", busy1, 1'b0);
        @(negedge clk);
        check("bp_no_capture", busy1, 1'b0);

        start1(8'hFF, 8'h01, 1'b0);
        wait1("x1_lat_ff", 8);
        check("x1_sum_ff", sum1, 8'h00);
        check("x1_cout_ff", cout1, 1'b1);
        release1();

        start1(8'h00, 8'h00, 1'b1);
        wait1("x1_lat_cin", 8);
        check("x1_sum_cin", sum1, 8'h01);
        check("x1_cout_cin", cout1, 1'b0);
        release1();

        // reset after three RUN steps
        start1(8'hFF, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ov", ov1, 1'b0);
        check("mid_rst_sum", sum1, 8'h00);
        check("mid_rst_cout", cout1, 1'b0);
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_ir", ir1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        start1(8'h12, 8'h34, 1'b0);
        wait1("x1_lat_12", 8);
        check("x1_sum_12", sum1, 8'h46);
        check("x1_cout_12", cout1, 1'b0);
        release1();

        // four bits per cycle
        start4(8'hA5, 8'h5B, 1'b0);
        wait4("x4_lat_a5", 2);
        check("x4_sum_a5", sum4, 8'h00);
        check("x4_cout_a5", cout4, 1'b1);
        release4();

        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ref9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            start4(ra, rb, rc);
            wait4("x4_lat_rnd", 2);
            check("x4_sum_rnd", sum4, ref9[7:0]);
            check("x4_cout_rnd", cout4, ref9[8]);
            release4();
        end

`ifdef SERIAL_ADDER_SUB_EN
        sub1 = 1'b1;
        start1(8'h05, 8'h07, 1'b0);
        wait1("sub_lat_05", 8);
        check("sub_sum_05", sum1, 8'hFE);
        check("sub_cout_05", cout1, 1'b0);
        check("sub_ovf_05", ovf1, 1'b0);
        release1();
        start1(8'h80, 8'h01, 1'b0);
        wait1("sub_lat_80", 8);
        check("sub_sum_80", sum1, 8'h7F);
        check("sub_cout_80", cout1, 1'b1);
        check("sub_ovf_80", ovf1, 1'b1);
        release1();
        sub1 = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
